adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 148 ++++++++++++++
 tb/tb_adder_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester front end that time-shares a single WIDTH-bit adder.
// Each op runs IDLE -> EXEC -> RESP, and the response is held until its owner accepts it.

module adder_arbiter_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
endmodule

module adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][1:0]       req_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [1:0]            rsp_flag,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_ctrl;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_flag;
  logic             r_err;

  logic             w_grant;
  logic             w_offer;
  logic             w_handshake;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_in;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_zero;

  // Round-robin: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    w_grant = req_valid[1];
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end
  end

  // rst_n gates the offer so req_ready drops the instant reset asserts.
  assign w_offer     = rst_n && (r_state == ST_IDLE) && (req_valid != 2'b00);
  assign w_handshake = |(req_valid & req_ready);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = w_offer && (w_grant == 1'(gi));
      assign rsp_valid[gi] = (r_state == ST_RESP) && (r_owner == 1'(gi));
    end
  endgenerate

  // SUB and CMP compute A + ~B + 1, so carry-out means "no borrow" (A >= B).
  assign w_sub  = (r_ctrl == OP_SUB) || (r_ctrl == OP_CMP);
  assign w_b_in = w_sub ? ~r_b : r_b;

  adder_arbiter_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_a),
    .i_b    (w_b_in),
    .i_cin  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_zero = (w_sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= OP_ADD;
      r_result     <= '0;
      r_flag       <= 2'b00;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_a          <= req_a[w_grant];
            r_b          <= req_b[w_grant];
            r_ctrl       <= req_ctrl[w_grant];
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_ctrl == OP_RSV) begin
            r_result <= '0;
            r_flag   <= 2'b00;
            r_err    <= 1'b1;
          end else begin
            r_result <= w_sum;
            r_flag   <= {w_cout & ~w_zero, w_zero};
            r_err    <= 1'b0;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[r_owner]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_result = r_result;
  assign rsp_flag   = r_flag;
  assign rsp_err    = r_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a table of single ops followed by
// round-robin, response-stall and mid-op reset sequences.

module tb_adder_arbiter;

  localparam int WIDTH = 16;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0][1:0]       req_ctrl;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [1:0]            rsp_flag;
  logic                  rsp_err;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  adder_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        who;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  ctrl;
    logic [15:0] res;
    logic [1:0]  flag;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One isolated op with rsp_ready tied high: offer, EXEC, RESP, back to IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] oh;
    oh = v.who ? 2'b10 : 2'b01;
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    req_valid[v.who] = 1'b1;
    req_a[v.who]     = v.a;
    req_b[v.who]     = v.b;
    req_ctrl[v.who]  = v.ctrl;
    #1 check("vec_req_ready", 32'(req_ready), 32'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    check("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("vec_exec_busy", 32'(busy), 32'd1);
    check("vec_exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("vec_rsp_valid", 32'(rsp_valid), 32'(oh));
    check("vec_result", 32'(rsp_result), 32'(v.res));
    check("vec_flag", 32'(rsp_flag), 32'(v.flag));
    check("vec_err", 32'(rsp_err), 32'(v.err));
    $display("[TB] vec %0d req%0d ctrl=%b a=%h b=%h -> result=%h flag=%b err=%b (exp %h %b %b)",
             idx, v.who, v.ctrl, v.a, v.b, rsp_result, rsp_flag, rsp_err, v.res, v.flag, v.err);
    @(negedge clk);
    check("vec_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("vec_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic seq_round_robin();
    int got;
    int last_cyc;
    int budget;
    logic [1:0]  exp_oh;
    logic [15:0] exp_res;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    req_a[0] = 16'h0001; req_b[0] = 16'h0001; req_ctrl[0] = 2'b00;
    req_a[1] = 16'h0010; req_b[1] = 16'h0020; req_ctrl[1] = 2'b00;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    got = 0; last_cyc = 0; budget = 0;
    while (got < 4 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (rsp_valid != 2'b00) begin
        exp_oh  = (got % 2 == 0) ? 2'b01 : 2'b10;
        exp_res = (got % 2 == 0) ? 16'h0002 : 16'h0030;
        check("rr_owner", 32'(rsp_valid), 32'(exp_oh));
        check("rr_result", 32'(rsp_result), 32'(exp_res));
        if (got > 0) check("rr_interval", 32'(cyc - last_cyc), 32'd3);
        $display("[TB] rr op %0d rsp_valid=%b result=%h cycle=%0d", got, rsp_valid, rsp_result, cyc);
        last_cyc = cyc;
        got++;
      end
    end
    req_valid = 2'b00;
    if (got < 4) check("rr_timeout", 32'(got), 32'd4);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic seq_stall();
    rsp_ready = 2'b00;
    req_a[0] = 16'h0007; req_b[0] = 16'h0008; req_ctrl[0] = 2'b00;
    req_valid = 2'b01;
    #1 check("stall_req_ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    // Operand change and a new request from req1 while busy must be ignored.
    req_a[0] = 16'hDEAD;
    req_a[1] = 16'h0002; req_b[1] = 16'h0003; req_ctrl[1] = 2'b00;
    req_valid = 2'b10;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'b01);
      check("stall_result", 32'(rsp_result), 32'h000F);
      check("stall_flag", 32'(rsp_flag), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      $display("[TB] stall cycle %0d rsp_valid=%b result=%h", k, rsp_valid, rsp_result);
      rsp_ready = 2'b10;
      @(negedge clk);
    end
    check("stall_nonowner_ignored", 32'(rsp_valid), 32'b01);
    rsp_ready = 2'b01;
    #1 check("stall_complete_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("stall_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stall_next_grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("stall_req1_rsp_valid", 32'(rsp_valid), 32'b10);
    check("stall_req1_result", 32'(rsp_result), 32'h0005);
    $display("[TB] stall follow-up req1 result=%h", rsp_result);
    @(negedge clk);
  endtask

  task automatic seq_reset_exec();
    int seen;
    req_a[0] = 16'h0001; req_b[0] = 16'h0002; req_ctrl[0] = 2'b00;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b11;
    check("rst_pre_busy", 32'(busy), 32'd1);
    check("rst_pre_rsp_valid", 32'(rsp_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flag", 32'(rsp_flag), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk) req_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen++;
    end
    check("rst_no_response", 32'(seen), 32'd0);
    req_a[1] = 16'h0100; req_b[1] = 16'h0001; req_ctrl[1] = 2'b00;
    req_valid = 2'b11;
    #1 check("rst_tie_grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("rst_after_rsp_valid", 32'(rsp_valid), 32'b01);
    check("rst_after_result", 32'(rsp_result), 32'h0003);
    $display("[TB] post-reset op rsp_valid=%b result=%h", rsp_valid, rsp_result);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0005, 16'h0003, 2'b00, 16'h0008, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 2'b01, 1'b0};
    vecs[2] = '{1'b0, 16'h0009, 16'h0004, 2'b01, 16'h0005, 2'b10, 1'b0};
    vecs[3] = '{1'b0, 16'h0004, 16'h0009, 2'b01, 16'hFFFB, 2'b00, 1'b0};
    vecs[4] = '{1'b0, 16'h1234, 16'h1234, 2'b10, 16'h0000, 2'b01, 1'b0};
    vecs[5] = '{1'b0, 16'h00AA, 16'h0055, 2'b11, 16'h0000, 2'b00, 1'b1};
    vecs[6] = '{1'b1, 16'h0005, 16'h0003, 2'b10, 16'h0002, 2'b10, 1'b0};
    vecs[7] = '{1'b1, 16'h0003, 16'h0005, 2'b10, 16'hFFFE, 2'b00, 1'b0};
    vecs[8] = '{1'b1, 16'h8000, 16'h8000, 2'b00, 16'h0000, 2'b01, 1'b0};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 2'b01, 16'h0000, 2'b01, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    rsp_ready = 2'b11;
    #12;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(rsp_result), 32'd0);
    check("reset_flag_err", 32'({rsp_flag, rsp_err}), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    seq_round_robin();
    seq_stall();
    seq_reset_exec();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
